btb_assoc: RTL and testbench



---
 rtl/btb_pkg.sv | 32 +++
 rtl/btb_assoc_if.sv | 31 +++
 rtl/sat_counter_upd.sv | 32 +++
 rtl/btb_assoc.sv | 129 ++++++++++++
 tb/tb_btb_assoc.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/btb_pkg.sv
// Shared types and address/counter helpers for the set-associative branch target buffer.
// Entry fields are sized for the widest legal configuration; narrower instances zero-fill.
package btb_pkg;

    localparam int MAX_TAG_BITS = 30;
    localparam int MAX_CTR_BITS = 8;

    typedef struct packed {
        logic                    valid;
        logic [MAX_TAG_BITS-1:0] tag;
        logic [31:0]             target;
        logic [MAX_CTR_BITS-1:0] ctr;
    } btb_entry_t;

    function automatic logic [31:0] idx_of(input logic [31:0] pc, input int idx_bits);
        return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc, input int idx_bits,
                                           input int tag_bits);
        return (pc >> (idx_bits + 2)) & ((32'd1 << tag_bits) - 32'd1);
    endfunction

    function automatic logic [MAX_CTR_BITS-1:0] CTR_MAX(input int ctr_bits);
        return MAX_CTR_BITS'((32'd1 << ctr_bits) - 32'd1);
    endfunction

    function automatic logic [MAX_CTR_BITS-1:0] CTR_WEAK_TAKEN(input int ctr_bits);
        return MAX_CTR_BITS'(32'd1 << (ctr_bits - 1));
    endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-side prediction and commit-side training signals of the branch target buffer.
// master = fetch/commit pipeline, slave = the BTB itself.
interface btb_assoc_if;

    logic [31:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] next_pc;

    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_is_jal;
    logic        upd_is_branch;
    logic        upd_taken;
    logic        flush_all;

    modport master (
        output fetch_pc, upd_valid, upd_pc, upd_target, upd_is_jal, upd_is_branch,
               upd_taken, flush_all,
        input  pred_hit, pred_taken, pred_target, next_pc
    );

    modport slave (
        input  fetch_pc, upd_valid, upd_pc, upd_target, upd_is_jal, upd_is_branch,
               upd_taken, flush_all,
        output pred_hit, pred_taken, pred_target, next_pc
    );

endinterface

// File: rtl/sat_counter_upd.sv
// Next-value function of a saturating direction counter.
// Priority: set_max, then init_weak, then inc, then dec; otherwise hold.
module sat_counter_upd
    import btb_pkg::*;
#(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                inc,
    input  logic                dec,
    input  logic                set_max,
    input  logic                init_weak,
    output logic [CTR_BITS-1:0] ctr_nxt
);

    localparam logic [CTR_BITS-1:0] MAX_V  = CTR_BITS'(CTR_MAX(CTR_BITS));
    localparam logic [CTR_BITS-1:0] WEAK_V = CTR_BITS'(CTR_WEAK_TAKEN(CTR_BITS));

    always_comb begin
        ctr_nxt = ctr;
        if (set_max) begin
            ctr_nxt = MAX_V;
        end else if (init_weak) begin
            ctr_nxt = WEAK_V;
        end else if (inc) begin
            if (ctr != MAX_V) ctr_nxt = ctr + CTR_BITS'(1);
        end else if (dec) begin
            if (ctr != '0) ctr_nxt = ctr - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: combinational prediction at fetch, one training write per cycle
// from commit, round-robin victim choice once a set is full.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int SETS     = 16,
    parameter int WAYS     = 2,
    parameter int TAG_BITS = 14,
    parameter int CTR_BITS = 2
) (
    input logic        clk,
    input logic        rst,
    btb_assoc_if.slave bus
);

    localparam int IDX_BITS = $clog2(SETS);
    localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

    btb_entry_t          mem    [SETS][WAYS];
    logic [WAY_BITS-1:0] rr_ptr [SETS];

    // Fetch lookup
    logic [IDX_BITS-1:0]     f_idx;
    logic [MAX_TAG_BITS-1:0] f_tag;
    logic                    f_hit;
    logic [WAY_BITS-1:0]     f_way;
    btb_entry_t              f_entry;

    assign f_idx = IDX_BITS'(idx_of(bus.fetch_pc, IDX_BITS));
    assign f_tag = MAX_TAG_BITS'(tag_of(bus.fetch_pc, IDX_BITS, TAG_BITS));

    // Scan from the top so the lowest matching way is the one left standing.
    always_comb begin
        f_hit = 1'b0;
        f_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mem[f_idx][w].valid && mem[f_idx][w].tag == f_tag) begin
                f_hit = 1'b1;
                f_way = WAY_BITS'(w);
            end
        end
    end

    assign f_entry         = mem[f_idx][f_way];
    assign bus.pred_hit    = f_hit;
    assign bus.pred_taken  = f_hit & f_entry.ctr[CTR_BITS-1];
    assign bus.pred_target = f_hit ? f_entry.target : 32'd0;
    assign bus.next_pc     = bus.pred_taken ? bus.pred_target : bus.fetch_pc + 32'd4;

    // Training lookup and victim selection
    logic [IDX_BITS-1:0]     u_idx;
    logic [MAX_TAG_BITS-1:0] u_tag;
    logic                    u_hit;
    logic [WAY_BITS-1:0]     u_way;
    logic                    inv_found;
    logic [WAY_BITS-1:0]     inv_way;
    logic                    u_jal, u_br_t, u_br_nt;
    logic                    wr_en, tgt_en, ptr_adv;
    logic [WAY_BITS-1:0]     wr_way;
    logic [CTR_BITS-1:0]     ctr_cur, ctr_nxt;

    assign u_idx = IDX_BITS'(idx_of(bus.upd_pc, IDX_BITS));
    assign u_tag = MAX_TAG_BITS'(tag_of(bus.upd_pc, IDX_BITS, TAG_BITS));

    always_comb begin
        u_hit     = 1'b0;
        u_way     = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mem[u_idx][w].valid && mem[u_idx][w].tag == u_tag) begin
                u_hit = 1'b1;
                u_way = WAY_BITS'(w);
            end
            if (!mem[u_idx][w].valid) begin
                inv_found = 1'b1;
                inv_way   = WAY_BITS'(w);
            end
        end
    end

    // A jal flag overrides a simultaneous branch flag.
    assign u_jal   = bus.upd_valid & bus.upd_is_jal;
    assign u_br_t  = bus.upd_valid & bus.upd_is_branch & ~bus.upd_is_jal & bus.upd_taken;
    assign u_br_nt = bus.upd_valid & bus.upd_is_branch & ~bus.upd_is_jal & ~bus.upd_taken;

    assign tgt_en  = u_jal | u_br_t;
    assign wr_en   = ~bus.flush_all & (u_hit ? (tgt_en | u_br_nt) : tgt_en);
    assign wr_way  = u_hit ? u_way : (inv_found ? inv_way : rr_ptr[u_idx]);
    assign ptr_adv = wr_en & ~u_hit & ~inv_found;
    assign ctr_cur = u_hit ? CTR_BITS'(mem[u_idx][u_way].ctr) : '0;

    sat_counter_upd #(
        .CTR_BITS (CTR_BITS)
    ) u_ctr (
        .ctr       (ctr_cur),
        .inc       (u_br_t),
        .dec       (u_br_nt),
        .set_max   (u_jal),
        .init_weak (~u_hit & u_br_t),
        .ctr_nxt   (ctr_nxt)
    );

    // State update; tags and targets are left out of reset on purpose.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    mem[s][w].valid <= 1'b0;
                    mem[s][w].ctr   <= '0;
                end
                rr_ptr[s] <= '0;
            end
        end else if (bus.flush_all) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    mem[s][w].valid <= 1'b0;
                end
            end
        end else if (wr_en) begin
            mem[u_idx][wr_way].valid <= 1'b1;
            mem[u_idx][wr_way].tag   <= u_tag;
            mem[u_idx][wr_way].ctr   <= MAX_CTR_BITS'(ctr_nxt);
            if (tgt_en) mem[u_idx][wr_way].target <= bus.upd_target;
            if (ptr_adv) rr_ptr[u_idx] <= (WAYS > 1) ? rr_ptr[u_idx] + WAY_BITS'(1) : '0;
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed scoreboard bench for btb_assoc: stimulus queues expected fetch results,
// a negedge monitor pops and compares them.
module tb_btb_assoc;

    logic clk = 1'b1;
    logic rst = 1'b0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    btb_assoc_if bus ();

    btb_assoc #(
        .SETS     (16),
        .WAYS     (2),
        .TAG_BITS (14),
        .CTR_BITS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] nxt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        bus.upd_valid     = 1'b0;
        bus.upd_is_jal    = 1'b0;
        bus.upd_is_branch = 1'b0;
        bus.upd_taken     = 1'b0;
        bus.flush_all     = 1'b0;
        chk_en            = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic jal,
                       input logic br, input logic tk);
        bus.upd_valid     = 1'b1;
        bus.upd_pc        = pc;
        bus.upd_target    = tgt;
        bus.upd_is_jal    = jal;
        bus.upd_is_branch = br;
        bus.upd_taken     = tk;
    endtask

    task automatic chk(input string nm, input logic [31:0] pc, input logic hit,
                       input logic tk, input logic [31:0] tgt, input logic [31:0] nxt);
        exp_t e;
        e.name  = nm;
        e.hit   = hit;
        e.taken = tk;
        e.tgt   = tgt;
        e.nxt   = nxt;
        bus.fetch_pc = pc;
        exp_q.push_back(e);
        chk_en = 1'b1;
    endtask

    // Monitor: compares DUT outputs mid-cycle against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL queue_empty: fetch_pc=%h has no expected entry", bus.fetch_pc);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.pred_hit, bus.pred_taken, bus.pred_target, bus.next_pc} !==
                        {e.hit, e.taken, e.tgt, e.nxt}) begin
                        bad++;
                        $display("FAIL %s: got hit=%0b taken=%0b target=%h next=%h, want hit=%0b taken=%0b target=%h next=%h",
                                 e.name, bus.pred_hit, bus.pred_taken, bus.pred_target, bus.next_pc,
                                 e.hit, e.taken, e.tgt, e.nxt);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation ran past 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        bus.fetch_pc      = 32'h0;
        bus.upd_valid     = 1'b0;
        bus.upd_pc        = 32'h0;
        bus.upd_target    = 32'h0;
        bus.upd_is_jal    = 1'b0;
        bus.upd_is_branch = 1'b0;
        bus.upd_taken     = 1'b0;
        bus.flush_all     = 1'b0;
        rst = 1'b1;
        chk("reset", 32'h6000_0000, 0, 0, 32'h0, 32'h6000_0004);
        tick();
        tick();
        rst = 1'b0;
        chk("post_reset", 32'h6000_0000, 0, 0, 32'h0, 32'h6000_0004);
        tick();
        upd(32'h6000_0010, 32'h6000_0100, 1, 0, 0);
        tick();
        chk("jal_hit", 32'h6000_0010, 1, 1, 32'h6000_0100, 32'h6000_0100);
        upd(32'h6000_0020, 32'h6000_0200, 0, 1, 0);
        tick();
        chk("br_nt_miss", 32'h6000_0020, 0, 0, 32'h0, 32'h6000_0024);
        upd(32'h6000_0020, 32'h6000_0200, 0, 1, 1);
        tick();
        chk("br_t_hit", 32'h6000_0020, 1, 1, 32'h6000_0200, 32'h6000_0200);
        upd(32'h6000_0020, 32'h6000_0200, 0, 1, 0);
        tick();
        chk("br_nt_hit", 32'h6000_0020, 1, 0, 32'h6000_0200, 32'h6000_0024);
        upd(32'h6000_0020, 32'h6000_0200, 0, 1, 0);
        tick();
        chk("br_nt2", 32'h6000_0020, 1, 0, 32'h6000_0200, 32'h6000_0024);
        upd(32'h6000_0020, 32'h6000_0200, 0, 1, 0);
        tick();
        chk("br_sat0", 32'h6000_0020, 1, 0, 32'h6000_0200, 32'h6000_0024);
        upd(32'h6000_0020, 32'h6000_0200, 0, 1, 1);
        tick();
        chk("br_sat_recover", 32'h6000_0020, 1, 0, 32'h6000_0200, 32'h6000_0024);
        upd(32'h6000_0020, 32'h6000_0200, 0, 1, 1);
        tick();
        chk("br_retaken", 32'h6000_0020, 1, 1, 32'h6000_0200, 32'h6000_0200);
        upd(32'h6000_0040, 32'h6000_1040, 1, 0, 0);
        tick();
        chk("conf_a_hit", 32'h6000_0040, 1, 1, 32'h6000_1040, 32'h6000_1040);
        upd(32'h6000_0080, 32'h6000_1080, 1, 0, 0);
        tick();
        chk("conf_b_hit", 32'h6000_0080, 1, 1, 32'h6000_1080, 32'h6000_1080);
        upd(32'h6000_00C0, 32'h6000_10C0, 1, 0, 0);
        tick();
        chk("evict_a_miss", 32'h6000_0040, 0, 0, 32'h0, 32'h6000_0044);
        tick();
        chk("keep_b_hit", 32'h6000_0080, 1, 1, 32'h6000_1080, 32'h6000_1080);
        tick();
        chk("new_c_hit", 32'h6000_00C0, 1, 1, 32'h6000_10C0, 32'h6000_10C0);
        upd(32'h6000_0100, 32'h6000_1100, 1, 0, 0);
        tick();
        chk("rr_evict_b", 32'h6000_0080, 0, 0, 32'h0, 32'h6000_0084);
        tick();
        chk("rr_keep_c", 32'h6000_00C0, 1, 1, 32'h6000_10C0, 32'h6000_10C0);
        tick();
        chk("rr_new_d", 32'h6000_0100, 1, 1, 32'h6000_1100, 32'h6000_1100);
        tick();
        upd(32'h6000_0010, 32'h6000_0300, 1, 0, 0);
        chk("same_cycle_old", 32'h6000_0010, 1, 1, 32'h6000_0100, 32'h6000_0100);
        tick();
        chk("same_cycle_new", 32'h6000_0010, 1, 1, 32'h6000_0300, 32'h6000_0300);
        upd(32'h6000_0030, 32'h6000_0330, 1, 1, 0);
        tick();
        chk("jal_and_branch", 32'h6000_0030, 1, 1, 32'h6000_0330, 32'h6000_0330);
        upd(32'h6000_0034, 32'h6000_0334, 0, 0, 1);
        tick();
        chk("no_flag_noop", 32'h6000_0034, 0, 0, 32'h0, 32'h6000_0038);
        bus.flush_all = 1'b1;
        upd(32'h6000_0400, 32'h6000_0440, 1, 0, 0);
        tick();
        chk("flush_10", 32'h6000_0010, 0, 0, 32'h0, 32'h6000_0014);
        tick();
        chk("flush_drop_upd", 32'h6000_0400, 0, 0, 32'h0, 32'h6000_0404);
        tick();
        chk("flush_c0", 32'h6000_00C0, 0, 0, 32'h0, 32'h6000_00C4);
        tick();
        chk("flush_30", 32'h6000_0030, 0, 0, 32'h0, 32'h6000_0034);
        upd(32'h6000_0010, 32'h6000_0500, 1, 0, 0);
        tick();
        chk("retrain_hit", 32'h6000_0010, 1, 1, 32'h6000_0500, 32'h6000_0500);
        tick();
        rst = 1'b1;
        chk("async_reset", 32'h6000_0010, 0, 0, 32'h0, 32'h6000_0014);
        tick();
        rst = 1'b0;
        chk("after_reset", 32'h6000_0010, 0, 0, 32'h0, 32'h6000_0014);
        tick();
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
